muldiv_arbiter: RTL and testbench

Round-robin arbiter sharing one iterative MulDiv unit between two requesters, e.g. the integer pipeline and the SCIE multicycle path. It owns the MulDiv request/response handshake and admits at most one operation in flight. It tags each issued operation with the owning requester, routes the response back to that owner, and forwards the owner's kill during the MulDiv kill window. It sits between the issue logic and the MulDiv instance in system_top.

---
 rtl/muldiv_arb_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 31 +++
 rtl/muldiv_arbiter.sv | 178 +++++++++++++++++
 tb/tb_muldiv_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_arb_pkg.sv
// Purpose: shared types and constants for the two-requester MulDiv arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: arbiter state enum, default XLEN/TAG_W, MulDiv function codes.
package muldiv_arb_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int TAG_W_DEF = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // MulDiv function codes (shared with the ALU encoding).
   localparam logic [3:0] FN_MUL    = 4'd0;
   localparam logic [3:0] FN_MULH   = 4'd1;
   localparam logic [3:0] FN_MULHSU = 4'd2;
   localparam logic [3:0] FN_MULHU  = 4'd3;
   localparam logic [3:0] FN_DIV    = 4'd4;
   localparam logic [3:0] FN_DIVU   = 4'd5;
   localparam logic [3:0] FN_REM    = 4'd6;
   localparam logic [3:0] FN_REMU   = 4'd7;

endpackage

// File: rtl/rr_arb2.sv
// Purpose: two-input round-robin grant with a priority register.
// Latency: grant is combinational; priority updates on the advance edge.
// Backpressure: caller asserts advance only when the granted request fires.
// Ports: clock/reset (sync, active-high), valid0/valid1 requests,
//        advance (grant consumed), winner (0 or 1).
module rr_arb2 (
   input  logic clock,
   input  logic reset,
   input  logic valid0,
   input  logic valid1,
   input  logic advance,
   output logic winner
);

   // prio names the requester that wins a tie.
   logic prio;

   // A lone requester always wins; a tie goes to prio.
   always_comb begin
      winner = (valid0 & valid1) ? prio : valid1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prio <= 1'b0;
      end else if (advance) begin
         prio <= ~winner;
      end
   end

endmodule

// File: rtl/muldiv_arbiter.sv
// Purpose: shares one iterative MulDiv between two requesters, one op in flight.
// Latency: zero added on request and response; total equals MulDiv latency.
// Backpressure: requesters stall while busy; owner's resp_ready gates the MulDiv response.
// Ports: clock/reset (sync, active-high); req0_*/req1_* requests with kill;
//        resp0_*/resp1_* routed results; mdu_* MulDiv handshake; busy, owner;
//        perf_grant0/perf_grant1/perf_conflict counters.
// Build option: define MULDIV_ARB_PERF_EN to instantiate the perf counters,
//               otherwise the perf_* ports are tied to zero.
module muldiv_arbiter
   import muldiv_arb_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_fn,
   input  logic             req0_dw,
   input  logic [XLEN-1:0]  req0_in1,
   input  logic [XLEN-1:0]  req0_in2,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req0_kill,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_fn,
   input  logic             req1_dw,
   input  logic [XLEN-1:0]  req1_in1,
   input  logic [XLEN-1:0]  req1_in2,
   input  logic [TAG_W-1:0] req1_tag,
   input  logic             req1_kill,
   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic [XLEN-1:0]  resp0_data,
   output logic [TAG_W-1:0] resp0_tag,
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [XLEN-1:0]  resp1_data,
   output logic [TAG_W-1:0] resp1_tag,
   output logic             mdu_req_valid,
   input  logic             mdu_req_ready,
   output logic [3:0]       mdu_req_fn,
   output logic             mdu_req_dw,
   output logic [XLEN-1:0]  mdu_req_in1,
   output logic [XLEN-1:0]  mdu_req_in2,
   output logic [TAG_W:0]   mdu_req_tag,
   output logic             mdu_kill,
   input  logic             mdu_resp_valid,
   output logic             mdu_resp_ready,
   input  logic [XLEN-1:0]  mdu_resp_data,
   input  logic [TAG_W:0]   mdu_resp_tag,
   output logic             busy,
   output logic             owner,
   output logic [31:0]      perf_grant0,
   output logic [31:0]      perf_grant1,
   output logic [31:0]      perf_conflict
);

   arb_state_t state_q, state_d;
   logic       owner_q;
   logic       kill_win_q;
   logic       winner;
   logic       req_fire;
   logic       owner_kill;
   logic       unused_resp_owner_bit;

   rr_arb2 u_rr (
      .clock   (clock),
      .reset   (reset),
      .valid0  (req0_valid),
      .valid1  (req1_valid),
      .advance (req_fire),
      .winner  (winner)
   );

   assign req_fire = mdu_req_valid & mdu_req_ready;

   // Request fields follow the winner; only sampled by MulDiv when valid.
   assign mdu_req_fn  = winner ? req1_fn  : req0_fn;
   assign mdu_req_dw  = winner ? req1_dw  : req0_dw;
   assign mdu_req_in1 = winner ? req1_in1 : req0_in1;
   assign mdu_req_in2 = winner ? req1_in2 : req0_in2;
   assign mdu_req_tag = {winner, (winner ? req1_tag : req0_tag)};

   // Response payload is broadcast; only the owner's valid is raised.
   // Routing trusts owner_q, so the owner bit echoed in the tag is not used.
   assign resp0_data = mdu_resp_data;
   assign resp1_data = mdu_resp_data;
   assign resp0_tag  = mdu_resp_tag[TAG_W-1:0];
   assign resp1_tag  = mdu_resp_tag[TAG_W-1:0];
   assign unused_resp_owner_bit = mdu_resp_tag[TAG_W];

   assign owner_kill = owner_q ? req1_kill : req0_kill;
   assign busy       = (state_q == BUSY);
   assign owner      = owner_q;

   always_comb begin
      state_d        = state_q;
      mdu_req_valid  = 1'b0;
      req0_ready     = 1'b0;
      req1_ready     = 1'b0;
      mdu_kill       = 1'b0;
      resp0_valid    = 1'b0;
      resp1_valid    = 1'b0;
      mdu_resp_ready = 1'b0;
      case (state_q)
         IDLE: begin
            mdu_req_valid = req0_valid | req1_valid;
            req0_ready    = ~winner & mdu_req_ready;
            req1_ready    = winner & mdu_req_ready;
            if (mdu_req_valid & mdu_req_ready) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            mdu_kill = kill_win_q & owner_kill;
            // A kill in the window beats a same-cycle response: drop it.
            if (mdu_kill) begin
               state_d = IDLE;
            end else begin
               resp0_valid    = ~owner_q & mdu_resp_valid;
               resp1_valid    = owner_q & mdu_resp_valid;
               mdu_resp_ready = owner_q ? resp1_ready : resp0_ready;
               if (mdu_resp_valid & mdu_resp_ready) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         kill_win_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         // Kill window is exactly the first BUSY cycle.
         kill_win_q <= req_fire;
         if (req_fire) begin
            owner_q <= winner;
         end
      end
   end

`ifdef MULDIV_ARB_PERF_EN
   logic [31:0] grant0_cnt_q, grant1_cnt_q, conflict_cnt_q;
   logic        both_accepted;

   assign both_accepted = (req0_valid & req0_ready) & (req1_valid & req1_ready);

   always_ff @(posedge clock) begin
      if (reset) begin
         grant0_cnt_q   <= 32'd0;
         grant1_cnt_q   <= 32'd0;
         conflict_cnt_q <= 32'd0;
      end else begin
         if (req_fire & ~winner) grant0_cnt_q <= grant0_cnt_q + 32'd1;
         if (req_fire & winner)  grant1_cnt_q <= grant1_cnt_q + 32'd1;
         if (req0_valid & req1_valid & ~both_accepted) begin
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
         end
      end
   end

   assign perf_grant0   = grant0_cnt_q;
   assign perf_grant1   = grant1_cnt_q;
   assign perf_conflict = conflict_cnt_q;
`else
   assign perf_grant0   = 32'd0;
   assign perf_grant1   = 32'd0;
   assign perf_conflict = 32'd0;
`endif

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Purpose: self-checking bench for muldiv_arbiter with a MulDiv stand-in.
// Latency: bench drives at posedge+1ns and samples at posedge+3ns.
// Backpressure: randomised resp_ready / mdu_req_ready plus directed stalls.
module tb_muldiv_arbiter;
   import muldiv_arb_pkg::*;

   localparam int XLEN  = 32;
   localparam int TAG_W = 4;
`ifdef MULDIV_ARB_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic req0_valid, req0_ready, req0_dw, req0_kill;
   logic req1_valid, req1_ready, req1_dw, req1_kill;
   logic [3:0] req0_fn, req1_fn;
   logic [XLEN-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
   logic [TAG_W-1:0] req0_tag, req1_tag, resp0_tag, resp1_tag;
   logic resp0_valid, resp0_ready, resp1_valid, resp1_ready;
   logic [XLEN-1:0] resp0_data, resp1_data;
   logic mdu_req_valid, mdu_req_ready, mdu_req_dw, mdu_kill;
   logic [3:0] mdu_req_fn;
   logic [XLEN-1:0] mdu_req_in1, mdu_req_in2, mdu_resp_data;
   logic [TAG_W:0] mdu_req_tag, mdu_resp_tag;
   logic mdu_resp_valid, mdu_resp_ready, busy, owner;
   logic [31:0] perf_grant0, perf_grant1, perf_conflict;

   always #5 clock = ~clock;

   muldiv_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fn(req0_fn), .req0_dw(req0_dw),
      .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_tag(req0_tag), .req0_kill(req0_kill),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fn(req1_fn), .req1_dw(req1_dw),
      .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_tag(req1_tag), .req1_kill(req1_kill),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data), .resp0_tag(resp0_tag),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data), .resp1_tag(resp1_tag),
      .mdu_req_valid(mdu_req_valid), .mdu_req_ready(mdu_req_ready), .mdu_req_fn(mdu_req_fn),
      .mdu_req_dw(mdu_req_dw), .mdu_req_in1(mdu_req_in1), .mdu_req_in2(mdu_req_in2),
      .mdu_req_tag(mdu_req_tag), .mdu_kill(mdu_kill), .mdu_resp_valid(mdu_resp_valid),
      .mdu_resp_ready(mdu_resp_ready), .mdu_resp_data(mdu_resp_data), .mdu_resp_tag(mdu_resp_tag),
      .busy(busy), .owner(owner),
      .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
   );

   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
      case (fn)
         FN_DIVU: return (b == 32'd0) ? 32'hffff_ffff : a / b;
         FN_REMU: return (b == 32'd0) ? a : a % b;
         default: return a * b;
      endcase
   endfunction

   // Requester-side pending operations.
   bit          pend [2];
   logic [3:0]  p_fn [2];
   logic [31:0] p_a  [2];
   logic [31:0] p_b  [2];
   logic [3:0]  p_tag[2];
   logic        p_dw [2];

   // Stimulus knobs (percentages / latency range).
   int p_new, p_rrdy, p_mrdy, lat_min, lat_max;
   int p_kill [2];
   int p_noise[2];

   // Reference model: one op in flight, ties go to whoever was not granted last.
   bit          m_busy, m_own, m_win, m_last;
   logic [31:0] e_data;
   logic [3:0]  e_tag;
   int          exp_g[2];
   int          exp_conf;
   int          deliveries, kills;
   logic [31:0] last_data0;
   int          glog[$];

   // MulDiv stand-in.
   bit          md_busy;
   int          md_cnt;
   logic [31:0] md_res;
   logic [4:0]  md_tag;

   task automatic new_op(input int i, input logic [3:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tg);
      pend[i]  = 1'b1;
      p_fn[i]  = fn;
      p_a[i]   = a;
      p_b[i]   = b;
      p_tag[i] = tg;
      p_dw[i]  = 1'($urandom_range(1));
   endtask

   task automatic new_random_op(input int i);
      logic [3:0]  fn;
      logic [31:0] b;
      int sel;
      sel = $urandom_range(2);
      fn  = (sel == 0) ? FN_MUL : ((sel == 1) ? FN_DIVU : FN_REMU);
      b   = ($urandom_range(9) == 0) ? 32'd0 : $urandom;
      new_op(i, fn, $urandom, b, 4'($urandom_range(15)));
   endtask

   task automatic clear_model();
      pend[0] = 0; pend[1] = 0;
      m_busy = 0; m_own = 0; m_win = 0; m_last = 1;
      exp_g[0] = 0; exp_g[1] = 0; exp_conf = 0;
      md_busy = 0; md_cnt = 0;
   endtask

   task automatic drive_idle();
      req0_valid = 0; req0_fn = 0; req0_dw = 0; req0_in1 = 0; req0_in2 = 0; req0_tag = 0; req0_kill = 0;
      req1_valid = 0; req1_fn = 0; req1_dw = 0; req1_in1 = 0; req1_in2 = 0; req1_tag = 0; req1_kill = 0;
      resp0_ready = 0; resp1_ready = 0; mdu_req_ready = 0;
      mdu_resp_valid = 0; mdu_resp_data = 0; mdu_resp_tag = 0;
   endtask

   task automatic run_cycle();
      bit win, e_mrv, e_rdy0, e_rdy1, e_kill, e_rv0, e_rv1, e_mrr, o_rrdy;
      @(posedge clock);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (!pend[i] && $urandom_range(99) < p_new) new_random_op(i);
      end
      req0_valid = pend[0]; req0_fn = p_fn[0]; req0_dw = p_dw[0];
      req0_in1 = p_a[0]; req0_in2 = p_b[0]; req0_tag = p_tag[0];
      req1_valid = pend[1]; req1_fn = p_fn[1]; req1_dw = p_dw[1];
      req1_in1 = p_a[1]; req1_in2 = p_b[1]; req1_tag = p_tag[1];
      req0_kill = (m_busy && m_win && m_own == 0 && $urandom_range(99) < p_kill[0])
                  || ($urandom_range(99) < p_noise[0]);
      req1_kill = (m_busy && m_win && m_own == 1 && $urandom_range(99) < p_kill[1])
                  || ($urandom_range(99) < p_noise[1]);
      resp0_ready = ($urandom_range(99) < p_rrdy);
      resp1_ready = ($urandom_range(99) < p_rrdy);
      mdu_req_ready  = !md_busy && ($urandom_range(99) < p_mrdy);
      mdu_resp_valid = md_busy && (md_cnt == 0);
      mdu_resp_data  = md_busy ? md_res : $urandom;
      mdu_resp_tag   = md_tag;
      #2;
      // Expected outputs for this cycle.
      win = (pend[0] && pend[1]) ? !m_last : pend[1];
      e_mrv = 0; e_rdy0 = 0; e_rdy1 = 0; e_kill = 0; e_rv0 = 0; e_rv1 = 0; e_mrr = 0;
      o_rrdy = m_own ? resp1_ready : resp0_ready;
      if (!m_busy) begin
         e_mrv  = pend[0] | pend[1];
         e_rdy0 = !win && mdu_req_ready;
         e_rdy1 = win && mdu_req_ready;
      end else begin
         e_kill = m_win && (m_own ? req1_kill : req0_kill);
         e_rv0  = !m_own && mdu_resp_valid && !e_kill;
         e_rv1  = m_own && mdu_resp_valid && !e_kill;
         e_mrr  = !e_kill && o_rrdy;
      end
      check_eq("busy", busy, m_busy);
      check_eq("owner", owner, m_own);
      check_eq("mdu_req_valid", mdu_req_valid, e_mrv);
      check_eq("req0_ready", req0_ready, e_rdy0);
      check_eq("req1_ready", req1_ready, e_rdy1);
      check_eq("mdu_kill", mdu_kill, e_kill);
      check_eq("resp0_valid", resp0_valid, e_rv0);
      check_eq("resp1_valid", resp1_valid, e_rv1);
      check_eq("mdu_resp_ready", mdu_resp_ready, e_mrr);
      check_eq("perf_grant0", perf_grant0, PERF ? exp_g[0] : 0);
      check_eq("perf_grant1", perf_grant1, PERF ? exp_g[1] : 0);
      check_eq("perf_conflict", perf_conflict, PERF ? exp_conf : 0);
      if (e_mrv) begin
         check_eq("mdu_req_tag", mdu_req_tag, {win, p_tag[win]});
         check_eq("mdu_req_fn", mdu_req_fn, p_fn[win]);
         check_eq("mdu_req_dw", mdu_req_dw, p_dw[win]);
         check_eq("mdu_req_in1", mdu_req_in1, p_a[win]);
         check_eq("mdu_req_in2", mdu_req_in2, p_b[win]);
      end
      if (pend[0] && pend[1] && !(e_rdy0 && e_rdy1)) exp_conf++;
      // Reference model advances on the coming edge.
      if (!m_busy) begin
         if (e_mrv && mdu_req_ready) begin
            m_busy = 1; m_own = win; m_win = 1; m_last = win;
            exp_g[win]++;
            glog.push_back(int'(win));
            e_data = ref_result(p_fn[win], p_a[win], p_b[win]);
            e_tag  = p_tag[win];
         end
      end else begin
         m_win = 0;
         if (e_kill) begin
            m_busy = 0;
            kills++;
         end else if (mdu_resp_valid && o_rrdy) begin
            check_eq("resp_data", m_own ? resp1_data : resp0_data, e_data);
            check_eq("resp_tag", m_own ? resp1_tag : resp0_tag, e_tag);
            if (!m_own) last_data0 = resp0_data;
            deliveries++;
            m_busy = 0;
         end
      end
      // Environment follows the DUT's actual handshakes.
      if (req0_valid && req0_ready) pend[0] = 0;
      if (req1_valid && req1_ready) pend[1] = 0;
      if (md_busy) begin
         if (mdu_kill) md_busy = 0;
         else if (mdu_resp_valid && mdu_resp_ready) md_busy = 0;
         else if (md_cnt > 0) md_cnt--;
      end else if (mdu_req_valid && mdu_req_ready) begin
         md_busy = 1;
         md_cnt  = $urandom_range(lat_max, lat_min);
         md_res  = ref_result(mdu_req_fn, mdu_req_in1, mdu_req_in2);
         md_tag  = mdu_req_tag;
      end
   endtask

   task automatic do_reset(input int n);
      @(posedge clock);
      #1;
      reset = 1;
      drive_idle();
      repeat (n) @(posedge clock);
      #1;
      reset = 0;
      clear_model();
   endtask

   task automatic set_knobs(input int nw, input int rr, input int mr, input int lmin, input int lmax);
      p_new = nw; p_rrdy = rr; p_mrdy = mr; lat_min = lmin; lat_max = lmax;
      p_kill[0] = 0; p_kill[1] = 0; p_noise[0] = 0; p_noise[1] = 0;
   endtask

   initial begin
      int d0, k0;
      drive_idle();
      clear_model();
      deliveries = 0; kills = 0; last_data0 = 0;
      set_knobs(0, 100, 100, 1, 1);
      do_reset(2);
      #2;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_owner", owner, 0);
      check_eq("rst_mdu_req_valid", mdu_req_valid, 0);
      check_eq("rst_mdu_kill", mdu_kill, 0);
      check_eq("rst_resp0_valid", resp0_valid, 0);
      check_eq("rst_resp1_valid", resp1_valid, 0);
      check_eq("rst_perf_sum", perf_grant0 + perf_grant1 + perf_conflict, 0);

      // Single requester: 6*7 with tag 3.
      new_op(0, FN_MUL, 32'd6, 32'd7, 4'd3);
      repeat (5) run_cycle();
      check_eq("first_deliveries", deliveries, 1);
      check_eq("first_data", last_data0, 32'd42);

      // Both valid together: req0 first, then req1.
      do_reset(1);
      glog.delete();
      new_op(0, FN_DIVU, 32'd100, 32'd7, 4'd5);
      new_op(1, FN_REMU, 32'd100, 32'd7, 4'd9);
      repeat (10) run_cycle();
      check_eq("tie_grants", glog.size(), 2);
      if (glog.size() == 2) begin
         check_eq("tie_first", glog[0], 0);
         check_eq("tie_second", glog[1], 1);
      end

      // Owner kill in the window drops the op.
      k0 = kills; d0 = deliveries;
      set_knobs(0, 100, 100, 0, 2);
      p_kill[1] = 100;
      new_op(1, FN_MUL, 32'd3, 32'd4, 4'd1);
      repeat (4) run_cycle();
      check_eq("kill_count", kills - k0, 1);
      check_eq("kill_no_resp", deliveries - d0, 0);

      // Non-owner kill is ignored.
      k0 = kills; d0 = deliveries;
      set_knobs(0, 100, 100, 0, 2);
      p_noise[1] = 100;
      new_op(0, FN_MUL, 32'd9, 32'd9, 4'd2);
      repeat (6) run_cycle();
      check_eq("noise_kills", kills - k0, 0);
      check_eq("noise_deliv", deliveries - d0, 1);

      // Owner stalls the response; a waiting req1 must not be granted.
      d0 = deliveries;
      set_knobs(0, 0, 100, 0, 0);
      new_op(0, FN_MUL, 32'd2, 32'd5, 4'd4);
      run_cycle();
      new_op(1, FN_MUL, 32'd1, 32'd1, 4'd6);
      repeat (6) run_cycle();
      check_eq("stall_busy", busy, 1);
      check_eq("stall_deliv", deliveries - d0, 0);
      p_rrdy = 100;
      repeat (6) run_cycle();
      check_eq("stall_release", deliveries - d0, 2);

      // Randomised traffic.
      set_knobs(40, 70, 70, 0, 3);
      p_kill[0] = 20; p_kill[1] = 20; p_noise[0] = 10; p_noise[1] = 10;
      repeat (2000) run_cycle();
      check_eq("random_progress", (deliveries > 50), 1);

      // Reset in the middle of an operation.
      set_knobs(0, 100, 100, 10, 12);
      new_op(1, FN_MUL, 32'd8, 32'd8, 4'd7);
      repeat (3) run_cycle();
      check_eq("pre_reset_busy", busy, 1);
      do_reset(1);
      #2;
      check_eq("post_reset_busy", busy, 0);
      check_eq("post_reset_owner", owner, 0);
      check_eq("post_reset_perf", perf_grant0 + perf_grant1 + perf_conflict, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
